// File: rtl/cnn_layer_accel_trans_eg_drain.sv
// Transfer egress drain: pops {meta, payload} words from a non-FWFT FIFO
// and serializes the payload into OUT_WTH-wide valid/ready beats.
module cnn_layer_accel_trans_eg_drain #(
    parameter int unsigned PYLD_WTH = 1024,
    parameter int unsigned META_WTH = 64,
    parameter int unsigned OUT_WTH  = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    output logic                         fifo_rd_en,
    input  logic [META_WTH+PYLD_WTH-1:0] fifo_dout,
    input  logic                         fifo_empty,
    input  logic                         fifo_valid,
    output logic [OUT_WTH-1:0]           m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic                         m_tlast,
    output logic [META_WTH-1:0]          m_tuser,
    output logic                         busy,
    output logic                         err,
    output logic [15:0]                  xfer_cnt
);

    localparam int unsigned NSLICE = PYLD_WTH / OUT_WTH;
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned NB_W   = 16;

    // Elaboration-time parameter sanity
    if (META_WTH < 17) begin : g_meta_chk
        $error("META_WTH must be at least 17");
    end
    if ((PYLD_WTH % OUT_WTH) != 0) begin : g_slice_chk
        $error("PYLD_WTH must be a multiple of OUT_WTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                           state;
    logic                             armed;
    logic [NSLICE-1:0][OUT_WTH-1:0]   hold_pyld;
    logic [META_WTH-1:0]              hold_meta;
    logic [IDX_W-1:0]                 idx;
    logic [IDX_W-1:0]                 last_idx;
    logic                             eop_q;

    logic [META_WTH-1:0]              in_meta;
    logic [NB_W-1:0]                  in_nbeat;
    logic                             in_eop;
    logic                             nb_zero;
    logic                             nb_over;
    logic [IDX_W-1:0]                 in_last;
    logic                             beat_last;

    // Decode the metadata of the word presented on the FIFO read port
    assign in_meta  = fifo_dout[META_WTH+PYLD_WTH-1 -: META_WTH];
    assign in_nbeat = in_meta[NB_W-1:0];
    assign in_eop   = in_meta[NB_W];
    assign nb_zero  = (in_nbeat == '0);
    assign nb_over  = (32'(in_nbeat) > NSLICE);
    assign in_last  = nb_over ? IDX_W'(NSLICE - 1) : IDX_W'(in_nbeat - NB_W'(1));

    // Read strobe: only from IDLE, suppressed until the first clock after reset
    assign fifo_rd_en = armed && (state == IDLE) && en && !fifo_empty;

    // Stream outputs are pure functions of registered state
    assign beat_last = (idx == last_idx);
    assign m_tvalid  = (state == SEND);
    assign m_tdata   = hold_pyld[idx];
    assign m_tuser   = hold_meta;
    assign m_tlast   = (state == SEND) && eop_q && beat_last;
    assign busy      = (state != IDLE);

    // Drain FSM with hold registers, beat index, error flag and transfer count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            hold_pyld <= '0;
            hold_meta <= '0;
            idx       <= '0;
            last_idx  <= '0;
            eop_q     <= 1'b0;
            err       <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (fifo_rd_en) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (fifo_valid) begin
                        if (nb_zero) begin
                            // empty word carries nothing to send: flag and drop
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            hold_pyld <= fifo_dout[PYLD_WTH-1:0];
                            hold_meta <= in_meta;
                            eop_q     <= in_eop;
                            last_idx  <= in_last;
                            idx       <= '0;
                            if (nb_over) begin
                                err <= 1'b1;
                            end
                            state <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (m_tready) begin
                        if (beat_last) begin
                            state <= IDLE;
                            if (eop_q) begin
                                xfer_cnt <= xfer_cnt + 16'd1;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_trans_eg_drain.sv
// Directed bench for the transfer egress drain with a small FIFO model.
module tb_cnn_layer_accel_trans_eg_drain;

    localparam int unsigned PYLD_WTH = 1024;
    localparam int unsigned META_WTH = 64;
    localparam int unsigned OUT_WTH  = 128;
    localparam int unsigned NSLICE   = PYLD_WTH / OUT_WTH;
    localparam int unsigned DW       = META_WTH + PYLD_WTH;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                en = 1'b0;
    logic                fifo_rd_en;
    logic [DW-1:0]       fifo_dout = '0;
    logic                fifo_empty;
    logic                fifo_valid = 1'b0;
    logic [OUT_WTH-1:0]  m_tdata;
    logic                m_tvalid;
    logic                m_tready = 1'b1;
    logic                m_tlast;
    logic [META_WTH-1:0] m_tuser;
    logic                busy;
    logic                err;
    logic [15:0]         xfer_cnt;

    cnn_layer_accel_trans_eg_drain #(
        .PYLD_WTH(PYLD_WTH),
        .META_WTH(META_WTH),
        .OUT_WTH (OUT_WTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_valid(fifo_valid),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .busy      (busy),
        .err       (err),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model: non-FWFT, one-cycle read latency
    logic [DW-1:0] mem [32];
    int            n_push = 0;
    int            n_pop  = 0;
    assign fifo_empty = (n_push == n_pop);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_valid <= 1'b0;
        end else begin
            fifo_valid <= fifo_rd_en;
            if (fifo_rd_en) begin
                fifo_dout <= mem[n_pop % 32];
                n_pop     <= n_pop + 1;
            end
        end
    end

    task automatic push(input logic [DW-1:0] w);
        mem[n_push % 32] = w;
        n_push++;
    endtask

    function automatic logic [DW-1:0] mk(input int nb, input bit eop, input int base);
        logic [PYLD_WTH-1:0] p;
        logic [META_WTH-1:0] m;
        for (int i = 0; i < int'(NSLICE); i++) begin
            p[i*OUT_WTH +: OUT_WTH] = OUT_WTH'(base + i + 1);
        end
        m = {32'hA5A5_0000 | 32'(base), 15'd0, eop, 16'(nb)};
        return {m, p};
    endfunction

    // Monitor at negedge: record handshakes, read strobes, check stall stability
    int                  cyc = 0;
    int                  rd_cyc[$];
    logic [OUT_WTH-1:0]  bd[$];
    logic                bl[$];
    logic [META_WTH-1:0] bu[$];
    int                  bc[$];
    logic                stall_q = 1'b0;
    logic [OUT_WTH-1:0]  sd;
    logic                sl;
    logic [META_WTH-1:0] su;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && fifo_rd_en) rd_cyc.push_back(cyc);
        if (rst_n && m_tvalid && m_tready) begin
            bd.push_back(m_tdata);
            bl.push_back(m_tlast);
            bu.push_back(m_tuser);
            bc.push_back(cyc);
        end
        if (rst_n && stall_q) begin
            check("stall_valid", 128'(m_tvalid), 128'(1));
            check("stall_data", 128'(m_tdata), 128'(sd));
            check("stall_last", 128'(m_tlast), 128'(sl));
            check("stall_user", 128'(m_tuser), 128'(su));
        end
        stall_q = rst_n && m_tvalid && !m_tready;
        sd = m_tdata;
        sl = m_tlast;
        su = m_tuser;
    end

    task automatic clear();
        bd.delete();
        bl.delete();
        bu.delete();
        bc.delete();
        rd_cyc.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run until n beats collected (bounded), optionally toggling m_tready
    task automatic run(input int nbeats, input bit toggle, input int budget);
        int k = 0;
        while (bd.size() < nbeats && k < budget) begin
            tick();
            m_tready = toggle ? ~m_tready : 1'b1;
            k++;
        end
        if (bd.size() < nbeats) check("timeout", 128'(bd.size()), 128'(nbeats));
        repeat (4) begin
            tick();
            m_tready = 1'b1;
        end
    endtask

    task automatic wait_first_beat(input int budget);
        int k = 0;
        while (bd.size() < 1 && k < budget) begin
            tick();
            k++;
        end
        if (bd.size() < 1) check("timeout_first", 128'(bd.size()), 128'(1));
    endtask

    // Check n beats starting at off: data base+i+1, tlast only on final beat if eop
    task automatic chk_word(input string tag, input int off, input int n, input int base, input bit eop);
        for (int i = 0; i < n; i++) begin
            if (off + i < bd.size()) begin
                check({tag, "_data"}, 128'(bd[off+i]), 128'(base + i + 1));
                check({tag, "_last"}, 128'(bl[off+i]), 128'(eop && (i == n - 1)));
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_tvalid"}, 128'(m_tvalid), 128'(0));
        check({tag, "_tlast"}, 128'(m_tlast), 128'(0));
        check({tag, "_tdata"}, 128'(m_tdata), 128'(0));
        check({tag, "_tuser"}, 128'(m_tuser), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_err"}, 128'(err), 128'(0));
        check({tag, "_xfer"}, 128'(xfer_cnt), 128'(0));
        check({tag, "_rd_en"}, 128'(fifo_rd_en), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w;

        // Reset state
        rst_n = 1'b0;
        en = 1'b1;
        m_tready = 1'b1;
        repeat (3) tick();
        chk_reset("rst");
        rst_n = 1'b1;
        tick();

        // Single word, 8 beats, eop
        clear();
        w = mk(8, 1'b1, 0);
        push(w);
        run(8, 1'b0, 100);
        check("t1_nbeats", 128'(bd.size()), 128'(8));
        chk_word("t1", 0, 8, 0, 1'b1);
        if (bu.size() > 0) check("t1_user", 128'(bu[0]), 128'(w[DW-1 -: META_WTH]));
        check("t1_nreads", 128'(rd_cyc.size()), 128'(1));
        if (rd_cyc.size() > 0 && bc.size() == 8) begin
            check("t1_latency", 128'(bc[0] - rd_cyc[0]), 128'(2));
            check("t1_duration", 128'(bc[7] - rd_cyc[0]), 128'(9));
        end
        check("t1_xfer", 128'(xfer_cnt), 128'(1));
        check("t1_err", 128'(err), 128'(0));

        // Two words with m_tready toggling
        clear();
        push(mk(3, 1'b0, 16'h10));
        push(mk(2, 1'b1, 16'h20));
        run(5, 1'b1, 200);
        check("t2_nbeats", 128'(bd.size()), 128'(5));
        chk_word("t2a", 0, 3, 16'h10, 1'b0);
        chk_word("t2b", 3, 2, 16'h20, 1'b1);
        check("t2_nreads", 128'(rd_cyc.size()), 128'(2));
        if (rd_cyc.size() == 2 && bc.size() == 5) begin
            check("t2_next_read", 128'(rd_cyc[1]), 128'(bc[2] + 1));
        end
        check("t2_xfer", 128'(xfer_cnt), 128'(2));
        check("t2_err", 128'(err), 128'(0));

        // nbeat beyond slice count is clamped
        clear();
        push(mk(20, 1'b1, 16'h40));
        run(8, 1'b0, 100);
        check("t4_nbeats", 128'(bd.size()), 128'(NSLICE));
        chk_word("t4", 0, 8, 16'h40, 1'b1);
        check("t4_err", 128'(err), 128'(1));
        check("t4_xfer", 128'(xfer_cnt), 128'(3));

        // en low blocks reads; dropping en mid-word still completes it
        en = 1'b0;
        clear();
        push(mk(4, 1'b1, 16'h50));
        push(mk(1, 1'b1, 16'h60));
        repeat (20) tick();
        check("t5_no_read", 128'(rd_cyc.size()), 128'(0));
        check("t5_idle", 128'(busy), 128'(0));
        en = 1'b1;
        wait_first_beat(100);
        en = 1'b0;
        run(4, 1'b0, 100);
        repeat (10) tick();
        check("t5_nbeats", 128'(bd.size()), 128'(4));
        chk_word("t5", 0, 4, 16'h50, 1'b1);
        check("t5_nreads", 128'(rd_cyc.size()), 128'(1));
        check("t5_xfer", 128'(xfer_cnt), 128'(4));
        en = 1'b1;
        run(5, 1'b0, 100);
        if (bd.size() == 5) check("t5_tail_data", 128'(bd[4]), 128'(16'h61));
        check("t5_tail_xfer", 128'(xfer_cnt), 128'(5));

        // Reset asserted during beat 2 of a 6-beat word
        clear();
        push(mk(6, 1'b1, 16'h70));
        wait_first_beat(100);
        rst_n = 1'b0;
        #1;
        chk_reset("t6_mid");
        repeat (2) tick();
        rst_n = 1'b1;
        check("t6_partial", 128'(bd.size()), 128'(1));
        clear();
        push(mk(2, 1'b1, 16'h80));
        run(2, 1'b0, 100);
        check("t6_nbeats", 128'(bd.size()), 128'(2));
        chk_word("t6", 0, 2, 16'h80, 1'b1);
        check("t6_xfer", 128'(xfer_cnt), 128'(1));

        // nbeat zero word is dropped and flags err
        clear();
        check("t3_err_before", 128'(err), 128'(0));
        push(mk(0, 1'b1, 16'h90));
        push(mk(1, 1'b1, 16'hA0));
        run(1, 1'b0, 100);
        check("t3_nbeats", 128'(bd.size()), 128'(1));
        chk_word("t3", 0, 1, 16'hA0, 1'b1);
        check("t3_err", 128'(err), 128'(1));
        check("t3_nreads", 128'(rd_cyc.size()), 128'(2));
        check("t3_xfer", 128'(xfer_cnt), 128'(2));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_layer_accel_trans_eg_drain.md
# cnn_layer_accel_trans_eg_drain

Read-side drain engine for the transfer egress FIFO. Pops one {meta, payload} word at a time from the FIFO's read port (non-FWFT, one-cycle read latency) and serializes the PYLD_WTH payload into OUT_WTH-wide beats on a valid/ready stream toward the output interconnect. Metadata sets the number of valid beats and marks end-of-transfer. Sits in the rd_clk domain directly behind the egress FIFO pair.

## Interface
- PYLD_WTH, 1024, payload width of one FIFO word
- META_WTH, 64, metadata width of one FIFO word; must be at least 17
- OUT_WTH, 128, output beat width; PYLD_WTH % OUT_WTH == 0; NSLICE = PYLD_WTH/OUT_WTH
- clk  in  1  single clock (FIFO read clock)
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  permits starting new FIFO reads
- fifo_rd_en  out  1  FIFO read strobe
- fifo_dout  in  META_WTH+PYLD_WTH  {meta, pyld}, meta in upper bits
- fifo_empty  in  1  FIFO empty
- fifo_valid  in  1  fifo_dout valid (one cycle after fifo_rd_en)
- m_tdata  out  OUT_WTH  output beat
- m_tvalid  out  1  beat valid
- m_tready  in  1  downstream accept
- m_tlast  out  1  last beat of transfer
- m_tuser  out  META_WTH  meta of the word being sent
- busy  out  1  state != IDLE
- err  out  1  sticky bad-meta flag
- xfer_cnt  out  16  completed transfers (tlast beats accepted), wraps

## Operation
- Meta fields: meta[15:0] = nbeat (valid beats in word); meta[16] = eop; remaining bits are opaque, passed on m_tuser.
- Slice order: beat i = pyld[i*OUT_WTH +: OUT_WTH], slice 0 first.
- FSM states IDLE, WAIT, SEND.
  - IDLE: fifo_rd_en = en && !fifo_empty (combinational, one cycle max); if asserted -> WAIT.
  - WAIT: hold until fifo_valid; on fifo_valid capture pyld and meta into hold regs, idx <= 0. If nbeat == 0: set err, discard word, -> IDLE. If nbeat > NSLICE: set err, clamp to NSLICE, -> SEND. Otherwise -> SEND.
  - SEND: m_tvalid = 1, m_tdata = hold slice idx, m_tuser = held meta, m_tlast = eop && idx == nbeat-1. On m_tvalid && m_tready: if idx == nbeat-1 -> IDLE (xfer_cnt++ if eop), else idx++.
- fifo_rd_en is never asserted outside IDLE; at most one word outstanding.
- en low: no new reads; a word in WAIT/SEND still completes.
- m_tdata/m_tuser/m_tlast stable while m_tvalid && !m_tready.
- err cleared only by reset.

## Timing
- Reset values: fifo_rd_en 0, m_tvalid 0, m_tlast 0, m_tdata 0, m_tuser 0, busy 0, err 0, xfer_cnt 0, state IDLE, idx 0.
- Latency: fifo_rd_en at cycle T, fifo_valid at T+1 (captured end of T+1), first m_tvalid at T+2.
- Throughput with m_tready held high: a word of N beats takes N+2 cycles; the next fifo_rd_en is issued the cycle after the last beat handshake.
- m_tvalid and busy come directly from registered state; no combinational path from m_tready to m_tvalid.
- fifo_empty rising in the same cycle as a candidate read: no read.
- Reset mid-word: held word dropped, outputs return to reset values immediately (async), no partial beat completes.
- xfer_cnt wraps 0xFFFF -> 0x0000.

## Test plan
- Single word, nbeat=8, eop=1, pyld slice i = i+1, m_tready=1 -> 8 beats data 1..8, m_tlast only on beat 8, first m_tvalid 2 cycles after fifo_rd_en, xfer_cnt=1.
- Two words nbeat=3 eop=0 then nbeat=2 eop=1, m_tready toggling 1,0,1,0 -> 5 beats in order, data held stable during stalls, single m_tlast on 5th beat, xfer_cnt=1.
- Word nbeat=0 followed by nbeat=1 eop=1 -> first word emits no beats, err=1; second word emits 1 beat with m_tlast, err stays 1.
- nbeat=20 (> NSLICE=8) -> exactly 8 beats emitted, err=1.
- en=0 with fifo non-empty -> fifo_rd_en stays 0 for 20 cycles; en dropped during SEND of nbeat=4 -> all 4 beats sent, no further read.
- rst_n pulsed low during beat 2 of nbeat=6 -> m_tvalid 0 immediately, counters/err 0; after release next word read fresh from beat 0.
